writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage of the RV32I core; drives the register file write port.
//  Accepts one retiring instruction per handshake from the MEM stage.
//  For loads, waits for the data-memory response, then sign/zero-extends it.
//  Emits one registered write (reg3 / write_data_result / write_reg_enable) per instruction.
// PARAMETERS
//  XLEN        32  datapath width; only 32 is supported
//  REG_ADDR_W  5   register index width
// PORTS
//  clk               in   1     core clock, rising edge
//  rst_n             in   1     asynchronous active-low reset
//  in_valid          in   1     MEM stage offers an instruction
//  in_ready          out  1     stage can accept; transfer when in_valid && in_ready
//  in_rd             in   5     destination register index
//  in_rd_we          in   1     instruction writes rd
//  in_is_load        in   1     instruction is a load; result comes from dmem_rsp_data
//  in_funct3         in   3     load size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
//  in_addr_lo        in   2     low bits of the load byte address
//  in_alu_result     in   32    result for non-load instructions
//  dmem_rsp_valid    in   1     load data valid this cycle
//  dmem_rsp_data     in   32    raw aligned memory word
//  reg3              out  5     register file write index
//  write_data_result out  32    register file write data
//  write_reg_enable  out  1     register file write strobe, one cycle per write
//  retire            out  1     one-cycle pulse per completed instruction (incl. rd_we=0)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; in_ready=1; write_reg_enable=0,
//   retire=0, reg3=0, write_data_result=0. Any in-flight load is dropped.
//  States: IDLE, WAIT_LD. All outputs are registered except in_ready = (state==IDLE).
//  IDLE + accept non-load: next edge sets write_reg_enable = in_rd_we && (in_rd!=0),
//   reg3=in_rd, write_data_result=in_alu_result, retire=1. Stay IDLE. Latency is 1 cycle.
//   Back-to-back accepts give one write per cycle.
//  IDLE + accept load: latch rd, rd_we, funct3, addr_lo; go to WAIT_LD; no write this edge.
//  WAIT_LD: in_ready=0. On dmem_rsp_valid, the next edge writes the extended data
//   (strobe gated as above), pulses retire, and returns to IDLE.
//   Load-to-write latency is 1 cycle after the response. The response may arrive any
//   number of cycles later; no timeout.
//  dmem_rsp_valid while IDLE is ignored.
//  Same-cycle response and new offer: the offer is not accepted (in_ready=0 in WAIT_LD).
//  write_reg_enable and retire deassert the cycle after any pulse unless a new write occurs.
//  Extension: LB/LBU select byte addr_lo; LH/LHU select halfword addr_lo[1].
//   Signed forms replicate the MSB; unsigned forms zero-fill.
//   LW and the reserved codes 011/110/111 pass the word unchanged.
//  Writes to x0 are never issued (write_reg_enable=0), but retire still pulses.
// CONFIGURATION
//  WB_FWD_EN defined: adds outputs fwd_valid(1), fwd_rd(5), fwd_data(32) and ld_pending(1).
//   fwd_* mirror write_reg_enable/reg3/write_data_result combinationally, for EX bypass.
//   ld_pending = (state==WAIT_LD) && latched rd_we && rd!=0, for hazard stall.
//  WB_FWD_EN undefined: these ports and their logic are absent.
//   Behaviour of all other ports is identical.
// STRUCTURE
//  riscv_pkg: FUNCT3_LB/LH/LW/LBU/LHU constants, wb_state_t {IDLE, WAIT_LD}, XLEN.
//  Sub-module load_extend (combinational: raw word, funct3, addr_lo -> 32-bit result).
//   The FSM and output registers stay in writeback_stage.
// TESTING
//  ALU: rd=5, we=1, alu=0x1234_5678 -> next cycle we=1, reg3=5, data=0x12345678, retire=1.
//  Back-to-back ALU writes rd=1,2,3 over 3 cycles -> 3 consecutive single-cycle writes, in order.
//  LB: addr_lo=3, rsp 0x80FF_FF00 two cycles later -> in_ready=0 while waiting;
//   data=0xFFFF_FF80 one cycle after the response.
//   Same with LBU -> 0x0000_0080; LHU, addr_lo=2 -> 0x0000_80FF.
//  rd=0 with we=1 -> write_reg_enable stays 0, retire=1. rsp_valid while IDLE -> no activity.
//  rst_n low mid WAIT_LD -> immediate return to IDLE, in_ready=1, no write;
//   a late rsp_valid is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the writeback stage: datapath widths, load
// funct3 encodings and the writeback FSM state type.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Load size/sign encodings carried in funct3.
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } wb_state_t;

endpackage : riscv_pkg

// File: rtl/load_extend.sv
// Combinational load data formatter. It selects the addressed byte or halfword
// out of the aligned memory word, then sign- or zero-extends it to XLEN.
// LW and the reserved funct3 codes pass the word through unchanged.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] raw_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword lanes from the raw word.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    byte_sel = raw_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_sel = raw_i[7:0];
      2'd1: byte_sel = raw_i[15:8];
      2'd2: byte_sel = raw_i[23:16];
      2'd3: byte_sel = raw_i[31:24];
      default: byte_sel = raw_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  // Extend the selected lane according to the load size and signedness.
  always_comb begin
    result_o = raw_i;
    case (funct3_i)
      FUNCT3_LB:  result_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      FUNCT3_LBU: result_o = {{(XLEN-8){1'b0}}, byte_sel};
      FUNCT3_LH:  result_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      FUNCT3_LHU: result_o = {{(XLEN-16){1'b0}}, half_sel};
      default:    result_o = raw_i;
    endcase
  end

endmodule : load_extend

// File: rtl/writeback_stage.sv
// Final RV32I pipeline stage. Accepts one retiring instruction per handshake,
// waits for the data-memory response on loads, and issues one registered
// register-file write (plus a retire pulse) per instruction. Writes to x0 are
// suppressed but still retire.
// Optional feature macro: WB_FWD_EN adds the EX bypass outputs fwd_valid,
// fwd_rd, fwd_data and the load hazard flag ld_pending.
module writeback_stage
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rd_we,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic                  dmem_rsp_valid,
  input  logic [XLEN-1:0]       dmem_rsp_data,
  output logic [REG_ADDR_W-1:0] reg3,
  output logic [XLEN-1:0]       write_data_result,
  output logic                  write_reg_enable,
  output logic                  retire
`ifdef WB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data,
  output logic                  ld_pending
`endif
);

  wb_state_t             state_q;
  logic [REG_ADDR_W-1:0] ld_rd_q;
  logic                  ld_we_q;
  logic [2:0]            ld_funct3_q;
  logic [1:0]            ld_addr_lo_q;

  logic [REG_ADDR_W-1:0] wr_rd_q;
  logic [XLEN-1:0]       wr_data_q;
  logic                  wr_en_q;
  logic                  retire_q;

  logic [XLEN-1:0]       ld_result;

  load_extend u_load_extend (
    .raw_i     (dmem_rsp_data),
    .funct3_i  (ld_funct3_q),
    .addr_lo_i (ld_addr_lo_q),
    .result_o  (ld_result)
  );

  // The only combinational output: accept new work only when no load is open.
  assign in_ready = (state_q == IDLE);

  // Writeback FSM with registered write port and retire pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ld_rd_q      <= '0;
      ld_we_q      <= 1'b0;
      ld_funct3_q  <= '0;
      ld_addr_lo_q <= '0;
      wr_rd_q      <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      retire_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values regardless of statement order. The strobes default
      // low here and are raised below only when a write actually happens.
      wr_en_q  <= 1'b0;
      retire_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (in_is_load) begin
              ld_rd_q      <= in_rd;
              ld_we_q      <= in_rd_we;
              ld_funct3_q  <= in_funct3;
              ld_addr_lo_q <= in_addr_lo;
              state_q      <= WAIT_LD;
            end else begin
              wr_en_q   <= in_rd_we && (in_rd != '0);
              wr_rd_q   <= in_rd;
              wr_data_q <= in_alu_result;
              retire_q  <= 1'b1;
            end
          end
        end
        WAIT_LD: begin
          if (dmem_rsp_valid) begin
            wr_en_q   <= ld_we_q && (ld_rd_q != '0);
            wr_rd_q   <= ld_rd_q;
            wr_data_q <= ld_result;
            retire_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reg3              = wr_rd_q;
  assign write_data_result = wr_data_q;
  assign write_reg_enable  = wr_en_q;
  assign retire            = retire_q;

`ifdef WB_FWD_EN
  // Bypass taps mirror the write port; ld_pending flags an open load to a real rd.
  assign fwd_valid  = wr_en_q;
  assign fwd_rd     = wr_rd_q;
  assign fwd_data   = wr_data_q;
  assign ld_pending = (state_q == WAIT_LD) && ld_we_q && (ld_rd_q != '0);
`endif

endmodule : writeback_stage

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: a table of single-instruction
// vectors (ALU and every load extension form) plus hand-written sequences for
// back-to-back writes, idle responses, response/offer collision and reset.
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;
  logic [4:0]  reg3;
  logic [31:0] write_data_result;
  logic        write_reg_enable;
  logic        retire;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        ld_pending;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  writeback_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_rd             (in_rd),
    .in_rd_we          (in_rd_we),
    .in_is_load        (in_is_load),
    .in_funct3         (in_funct3),
    .in_addr_lo        (in_addr_lo),
    .in_alu_result     (in_alu_result),
    .dmem_rsp_valid    (dmem_rsp_valid),
    .dmem_rsp_data     (dmem_rsp_data),
    .reg3              (reg3),
    .write_data_result (write_data_result),
    .write_reg_enable  (write_reg_enable),
    .retire            (retire)
`ifdef WB_FWD_EN
    ,
    .fwd_valid         (fwd_valid),
    .fwd_rd            (fwd_rd),
    .fwd_data          (fwd_data),
    .ld_pending        (ld_pending)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] alu;
    logic [31:0] rsp;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_write(input string name, input logic we, input logic [4:0] rd,
                             input logic [31:0] data);
    check({name, ".we"},     {31'd0, write_reg_enable}, {31'd0, we});
    check({name, ".rd"},     {27'd0, reg3}, {27'd0, rd});
    check({name, ".data"},   write_data_result, data);
    check({name, ".retire"}, {31'd0, retire}, 32'd1);
`ifdef WB_FWD_EN
    check({name, ".fwd_valid"}, {31'd0, fwd_valid}, {31'd0, we});
    check({name, ".fwd_data"},  fwd_data, data);
`endif
  endtask

  task automatic check_quiet(input string name);
    check({name, ".we"},     {31'd0, write_reg_enable}, 32'd0);
    check({name, ".retire"}, {31'd0, retire}, 32'd0);
  endtask

  task automatic offer(input logic is_load, input logic [4:0] rd, input logic we,
                       input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu);
    in_valid      = 1'b1;
    in_is_load    = is_load;
    in_rd         = rd;
    in_rd_we      = we;
    in_funct3     = f3;
    in_addr_lo    = lo;
    in_alu_result = alu;
  endtask

  // Apply one vector: accept, (for loads) respond two cycles later, check the write.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    check({tag, ".ready_idle"}, {31'd0, in_ready}, 32'd1);
    offer(v.is_load, v.rd, v.we, v.funct3, v.addr_lo, v.alu);
    @(negedge clk);
    in_valid = 1'b0;
    if (!v.is_load) begin
      check_write(tag, v.exp_we, v.rd, v.exp_data);
    end else begin
      check_quiet({tag, ".accept"});
      check({tag, ".ready_wait1"}, {31'd0, in_ready}, 32'd0);
`ifdef WB_FWD_EN
      check({tag, ".ld_pending"}, {31'd0, ld_pending}, {31'd0, v.exp_we});
`endif
      @(negedge clk);
      check({tag, ".ready_wait2"}, {31'd0, in_ready}, 32'd0);
      dmem_rsp_valid = 1'b1;
      dmem_rsp_data  = v.rsp;
      @(negedge clk);
      dmem_rsp_valid = 1'b0;
      dmem_rsp_data  = 32'h0;
      check_write(tag, v.exp_we, v.rd, v.exp_data);
      check({tag, ".ready_back"}, {31'd0, in_ready}, 32'd1);
    end
    @(negedge clk);
    check_quiet({tag, ".after"});
  endtask

  function automatic vec_t mk(logic is_load, logic [4:0] rd, logic we, logic [2:0] f3,
                              logic [1:0] lo, logic [31:0] alu, logic [31:0] rsp,
                              logic exp_we, logic [31:0] exp_data);
    vec_t v;
    v.is_load = is_load; v.rd = rd; v.we = we; v.funct3 = f3; v.addr_lo = lo;
    v.alu = alu; v.rsp = rsp; v.exp_we = exp_we; v.exp_data = exp_data;
    return v;
  endfunction

  // Watchdog: the bench must never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            load rd     we   f3      lo    alu           rsp           exp_we exp_data
    vecs[0]  = mk(0, 5'd5,  1, 3'b000, 2'd0, 32'h1234_5678, 32'h0,        1, 32'h1234_5678);
    vecs[1]  = mk(0, 5'd0,  1, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0,        0, 32'hDEAD_BEEF);
    vecs[2]  = mk(0, 5'd7,  0, 3'b000, 2'd0, 32'hAAAA_5555, 32'h0,        0, 32'hAAAA_5555);
    vecs[3]  = mk(1, 5'd10, 1, 3'b000, 2'd3, 32'h0,         32'h80FF_FF00, 1, 32'hFFFF_FF80);
    vecs[4]  = mk(1, 5'd11, 1, 3'b100, 2'd3, 32'h0,         32'h80FF_FF00, 1, 32'h0000_0080);
    vecs[5]  = mk(1, 5'd12, 1, 3'b101, 2'd2, 32'h0,         32'h80FF_FF00, 1, 32'h0000_80FF);
    vecs[6]  = mk(1, 5'd13, 1, 3'b001, 2'd2, 32'h0,         32'h80FF_FF00, 1, 32'hFFFF_80FF);
    vecs[7]  = mk(1, 5'd13, 1, 3'b001, 2'd0, 32'h0,         32'h80FF_FF00, 1, 32'hFFFF_FF00);
    vecs[8]  = mk(1, 5'd17, 1, 3'b000, 2'd1, 32'h0,         32'h1234_5678, 1, 32'h0000_0056);
    vecs[9]  = mk(1, 5'd18, 1, 3'b000, 2'd0, 32'h0,         32'h1234_56F0, 1, 32'hFFFF_FFF0);
    vecs[10] = mk(1, 5'd14, 1, 3'b010, 2'd0, 32'h0,         32'hCAFE_BABE, 1, 32'hCAFE_BABE);
    vecs[11] = mk(1, 5'd15, 1, 3'b011, 2'd3, 32'h0,         32'h80FF_FF00, 1, 32'h80FF_FF00);
    vecs[12] = mk(1, 5'd16, 1, 3'b111, 2'd1, 32'h0,         32'h0102_0304, 1, 32'h0102_0304);
    vecs[13] = mk(1, 5'd0,  1, 3'b010, 2'd0, 32'h0,         32'h5555_AAAA, 0, 32'h5555_AAAA);
    vecs[14] = mk(1, 5'd9,  0, 3'b100, 2'd0, 32'h0,         32'h0000_00AB, 0, 32'h0000_00AB);
    vecs[15] = mk(1, 5'd19, 1, 3'b101, 2'd0, 32'h0,         32'h1234_F00D, 1, 32'h0000_F00D);

    rst_n = 1'b0;
    in_valid = 1'b0; in_rd = '0; in_rd_we = 1'b0; in_is_load = 1'b0;
    in_funct3 = '0; in_addr_lo = '0; in_alu_result = '0;
    dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst.ready", {31'd0, in_ready}, 32'd1);
    check("rst.we",    {31'd0, write_reg_enable}, 32'd0);
    check("rst.retire",{31'd0, retire}, 32'd0);
    check("rst.rd",    {27'd0, reg3}, 32'd0);
    check("rst.data",  write_data_result, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Back-to-back ALU writes rd=1,2,3: one write per cycle, in order.
    @(negedge clk);
    offer(0, 5'd1, 1, 3'b000, 2'd0, 32'h0000_0011);
    @(negedge clk);
    check_write("b2b1", 1'b1, 5'd1, 32'h0000_0011);
    offer(0, 5'd2, 1, 3'b000, 2'd0, 32'h0000_0022);
    @(negedge clk);
    check_write("b2b2", 1'b1, 5'd2, 32'h0000_0022);
    offer(0, 5'd3, 1, 3'b000, 2'd0, 32'h0000_0033);
    @(negedge clk);
    check_write("b2b3", 1'b1, 5'd3, 32'h0000_0033);
    in_valid = 1'b0;
    @(negedge clk);
    check_quiet("b2b.after");

    // Response while IDLE is ignored.
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    check_quiet("idle_rsp");
    check("idle_rsp.ready", {31'd0, in_ready}, 32'd1);
    check("idle_rsp.data",  write_data_result, 32'h0000_0033);

    // Response and a new offer in the same cycle: the offer waits one cycle.
    offer(1, 5'd20, 1, 3'b010, 2'd0, 32'h0);
    @(negedge clk);
    offer(0, 5'd21, 1, 3'b000, 2'd0, 32'h2121_2121);
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h2020_2020;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    check_write("coll.load", 1'b1, 5'd20, 32'h2020_2020);
    check("coll.ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_write("coll.alu", 1'b1, 5'd21, 32'h2121_2121);

    // Reset while waiting for a load: drop it, late response is ignored.
    @(negedge clk);
    offer(1, 5'd22, 1, 3'b010, 2'd0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check("rstw.ready_wait", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rstw.ready", {31'd0, in_ready}, 32'd1);
    check("rstw.we",    {31'd0, write_reg_enable}, 32'd0);
    check("rstw.rd",    {27'd0, reg3}, 32'd0);
    check("rstw.data",  write_data_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h2222_2222;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    check_quiet("rstw.late_rsp");
    check("rstw.late_data", write_data_result, 32'd0);
    @(negedge clk);
    check_quiet("rstw.after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_writeback_stage
